// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among REQS cache requesters.
// Each grant runs IDLE -> GRANT -> IDLE, so RAM enables always drop for a cycle between accesses.

module ram_arbiter_lane #(
   parameter int              DW      = 32,
   parameter logic [DW-1:0]   ERRWORD = DW'(32'hBAD1BAD1)
) (
   input  logic          sel,
   input  logic          done,
   input  logic          err,
   input  logic          is_write,
   input  logic [DW-1:0] ramload,
   output logic          iwait,
   output logic [DW-1:0] load
);
   logic fire;

   assign fire  = sel & done;
   assign iwait = ~fire;

   always_comb begin
      load = '0;
      if (fire) begin
         if (err)            load = ERRWORD;
         else if (!is_write) load = ramload;
      end
   end
endmodule

module ram_arbiter #(
   parameter int              REQS    = 4,
   parameter int              AW      = 32,
   parameter int              DW      = 32,
   parameter logic [DW-1:0]   ERRWORD = DW'(32'hBAD1BAD1)
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [REQS-1:0]           ren,
   input  logic [REQS-1:0]           wen,
   input  logic [REQS*AW-1:0]        addr,
   input  logic [REQS*DW-1:0]        store,
   output logic [REQS-1:0]           iwait,
   output logic [REQS*DW-1:0]        load,
   output logic                      ramREN,
   output logic                      ramWEN,
   output logic [AW-1:0]             ramaddr,
   output logic [DW-1:0]             ramstore,
   input  logic [DW-1:0]             ramload,
   input  logic [1:0]                ramstate,
   output logic [$clog2(REQS)-1:0]   grant_id,
   output logic                      busy,
   output logic                      bus_error
);
   localparam int              GW       = $clog2(REQS);
   localparam logic [GW-1:0]   LAST_IDX = GW'(REQS-1);
   localparam logic [1:0]      RS_ERROR = 2'd3;

   typedef enum logic {IDLE, GRANT} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   last_q, last_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic            bus_err_q, bus_err_d;

   logic [REQS-1:0] active;
   logic [GW-1:0]   win_idx;
   logic            win_vld;
   logic            in_grant;
   logic            g_ren, g_wen, g_act;
   logic [AW-1:0]   g_addr;
   logic [DW-1:0]   g_store;
   logic            done, err;

   assign active   = ren | wen;
   assign in_grant = (state_q == GRANT);

   // Scan starts one past the last completed owner, so each requester waits at most REQS-1 accesses.
   always_comb begin : rr_scan
      logic [GW-1:0] cand;
      cand    = last_q;
      win_idx = '0;
      win_vld = 1'b0;
      for (int k = 0; k < REQS; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + GW'(1);
         if (!win_vld && active[cand]) begin
            win_idx = cand;
            win_vld = 1'b1;
         end
      end
   end

   assign g_ren   = ren[grant_q];
   assign g_wen   = wen[grant_q];
   assign g_act   = g_ren | g_wen;
   assign g_addr  = addr[grant_q*AW +: AW];
   assign g_store = store[grant_q*DW +: DW];

   // Gating with nRST keeps a reset cycle from also presenting a completion pulse.
   assign done = in_grant & g_act & ramstate[1] & nRST;
   assign err  = done & (ramstate == RS_ERROR);

   assign ramWEN    = in_grant & g_wen;
   assign ramREN    = in_grant & g_ren & ~g_wen;
   assign ramaddr   = in_grant ? g_addr  : '0;
   assign ramstore  = in_grant ? g_store : '0;
   assign busy      = in_grant;
   assign grant_id  = grant_q;
   assign bus_error = bus_err_q;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      bus_err_d = bus_err_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               grant_d = win_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!g_act) begin
               state_d = IDLE;
            end else if (ramstate[1]) begin
               last_d  = grant_q;
               state_d = IDLE;
               if (ramstate == RS_ERROR) bus_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= IDLE;
         last_q    <= LAST_IDX;
         grant_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         bus_err_q <= bus_err_d;
      end
   end

   for (genvar i = 0; i < REQS; i++) begin : g_lane
      logic sel;
      assign sel = (grant_q == GW'(i));
      ram_arbiter_lane #(.DW(DW), .ERRWORD(ERRWORD)) u_lane (
         .sel      (sel),
         .done     (done),
         .err      (err),
         .is_write (g_wen),
         .ramload  (ramload),
         .iwait    (iwait[i]),
         .load     (load[i*DW +: DW])
      );
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Single-port RAM arbiter/scheduler placed between the cache level and the RAM-facing side of the memory controller.
- Shares one RAM port among REQS cache requesters with fair round-robin grant: default four (icache0, dcache0, icache1, dcache1), indexed 0..REQS-1.
- Sequences each grant through the RAM's ramstate handshake and returns wait/load to the winner only.
- Used by the multicore top in place of fixed-priority icache/dcache muxing.

Parameters:
- REQS, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- ERRWORD, 32'hBAD1BAD1, load value returned on RAM error.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- nRST  input  1  synchronous active-low reset, sampled on rising CLK.
- ren  input  REQS  per-requester read request.
- wen  input  REQS  per-requester write request.
- addr  input  REQS*AW  packed addresses; requester i at [i*AW +: AW].
- store  input  REQS*DW  packed write data.
- iwait  output  REQS  per-requester wait; 0 only in the completion cycle.
- load  output  REQS*DW  packed read data; valid only in the completion cycle.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  AW  RAM address.
- ramstore  output  DW  RAM write data.
- ramload  input  DW  RAM read data.
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- grant_id  output  $clog2(REQS)  index of the current owner, registered.
- busy  output  1  high while in GRANT.
- bus_error  output  1  sticky; set on any ERROR completion.

Behaviour:
- Reset (nRST=0 at edge):
  - state=IDLE, last pointer=REQS-1, grant_id=0, bus_error=0.
  - Outputs while in IDLE after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait all 1, load all 0, busy=0.
  - Reset mid-GRANT aborts the access; no completion pulse is issued.
- A requester is active when ren[i]|wen[i]. If both are set, the access is a write; ramREN=0.
- IDLE:
  - RAM enables are 0.
  - Scan order is last+1, last+2, ... with wrap modulo REQS; the first active requester wins.
  - At the edge, grant_id<=winner and state<=GRANT. No active requester: stay IDLE.
- GRANT:
  - ramREN/ramWEN/ramaddr/ramstore are combinationally driven from requester grant_id's current inputs. busy=1.
  - ramstate FREE/BUSY: hold. iwait[grant_id]=1.
  - ramstate ACCESS: iwait[grant_id]=0 and load[grant_id]=ramload for read (0 for write), same cycle. At the edge, last<=grant_id, state<=IDLE.
  - ramstate ERROR: iwait[grant_id]=0, load[grant_id]=ERRWORD. At the edge, bus_error<=1, last<=grant_id, state<=IDLE.
  - Granted requester drops both enables before completion: no pulse; at the edge, state<=IDLE and last is unchanged.
- Non-granted requesters always see iwait=1 and load=0. Requesters must hold addr/store stable until iwait falls.
- Minimum turnaround: one IDLE cycle after each completion, so RAM enables drop for at least one cycle between accesses.
- Latency: request seen in cycle n gives RAM enable in n+1 and completion at the first ACCESS cycle, at the earliest n+1.
- Starvation bound: an active requester is granted within REQS-1 other accesses.

Test Plan:
- Reset, then only ren[1]=1 with addr1=0x40, ramstate BUSY for 2 cycles then ACCESS, ramload=0x1234 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait[1]=0 and load1=0x1234 in cycle 3 only; next cycle IDLE with ramREN=0.
- All four requesters active continuously, RAM ACCESS on each GRANT cycle -> grant_id sequence 0,1,2,3,0,1; each iwait pulses once per 4 accesses.
- ren[2]=wen[2]=1, addr2=0x80, store2=0xDEAD -> ramWEN=1, ramREN=0, ramstore=0xDEAD; load2=0 at completion.
- Granted requester 0 gets ramstate=ERROR -> iwait[0]=0, load0=0xBAD1BAD1, bus_error=1 and it stays 1 through later successful accesses until nRST=0.
- Requester 3 drops its request during GRANT while ramstate=BUSY -> no iwait pulse, return to IDLE; the next grant search starts after the previous last, not after 3.
- nRST=0 asserted in a GRANT cycle with ramstate=ACCESS -> no completion is recorded; after the edge, ramREN=ramWEN=0, iwait all 1, grant_id=0, requester 0 has first priority.
